step_display_unit: RTL

- Board-level companion stage directly downstream of the single-cycle CPU top.
- Consumes the CPU's four 16-bit debug words (PC/next PC, rs, rt, ALU/DB bus).
- Drives a 4-digit multiplexed 7-segment display.
- Generates the CPU's single-step clock from a debounced push-button.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 84 ++++++++
 rtl/step_display_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the step/display board stage: debounce state encoding,
// digit count and the active-low hex-to-segment table (g..a order).
package disp_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } deb_state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Index = hex nibble, value = {g,f,e,d,c,b,a}, low = segment lit.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/btn_debounce.sv
// Step-button synchroniser and debounce FSM; produces the glitch-free CPU step
// clock level and a one-cycle pulse per accepted press.
//
// state       | meaning
// RELEASED    | button accepted as released, cpu_clk low
// PRESS_CHK   | btn_s high, waiting for it to stay high long enough
// PRESSED     | button accepted as pressed, cpu_clk high
// RELEASE_CHK | btn_s low, waiting for it to stay low long enough
module btn_debounce
  import disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic Reset,
  input  logic btn_step,
  output logic cpu_clk,
  output logic step_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0] sync;
  logic btn_s;
  logic clk_nxt, pulse_nxt;

  assign btn_s = sync[1];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= RELEASED;
      cnt        <= '0;
      sync       <= 2'b00;
      cpu_clk    <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sync       <= {sync[0], btn_step};
      cpu_clk    <= clk_nxt;
      step_pulse <= pulse_nxt;
    end
  end

  // Check windows run as a down-counter: loaded on entry, accept at terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RELEASED: begin
        if (btn_s) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = CNT_LOAD;
        end
      end
      PRESS_CHK: begin
        if (!btn_s)            state_nxt = RELEASED;
        else if (cnt == '0)    state_nxt = PRESSED;
        else                   cnt_nxt   = cnt - 1'b1;
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = CNT_LOAD;
        end
      end
      RELEASE_CHK: begin
        if (btn_s)             state_nxt = PRESSED;
        else if (cnt == '0)    state_nxt = RELEASED;
        else                   cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = RELEASED;
    endcase
  end

  always_comb begin
    clk_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
    pulse_nxt = (state == PRESS_CHK) && (state_nxt == PRESSED);
  end

endmodule

// File: rtl/step_display_unit.sv
// Board stage after the single-cycle CPU: debounced single-step clock plus a
// 4-digit multiplexed hex display of one CPU debug word. Optional macro DISP_DP_EN.
module step_display_unit
  import disp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        btn_step,
  input  logic [1:0]  sel,
  input  logic [15:0] sign1,
  input  logic [15:0] sign2,
  input  logic [15:0] sign3,
  input  logic [15:0] sign4,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  logic [SCAN_W-1:0] scan_cnt;
  logic [IDX_W-1:0]  idx;
  logic [15:0]       frame;
  logic [15:0]       word_sel;
  logic              fresh;
  logic              scan_wrap;
  logic              dp_bit;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK        (CLK),
    .Reset      (Reset),
    .btn_step   (btn_step),
    .cpu_clk    (cpu_clk),
    .step_pulse (step_pulse)
  );

  always_comb begin
    word_sel = sign1;
    unique case (sel)
      2'd0: word_sel = sign1;
      2'd1: word_sel = sign2;
      2'd2: word_sel = sign3;
      2'd3: word_sel = sign4;
      default: word_sel = sign1;
    endcase
  end

  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

`ifdef DISP_DP_EN
  assign dp_bit = (idx != IDX_W'(2));
`else
  assign dp_bit = 1'b1;
`endif

  // Blank for the cycle the index moves so the old pattern never lights the new digit.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      frame    <= '0;
      fresh    <= 1'b1;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
    end else begin
      fresh    <= 1'b0;
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (scan_wrap)
        idx <= idx + 1'b1;
      if (fresh || (scan_wrap && idx == IDX_W'(NUM_DIGITS - 1)))
        frame <= word_sel;
      if (fresh || scan_wrap) begin
        an  <= 4'b1111;
        seg <= SEG_BLANK;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= {dp_bit, HEX_SEG[frame[{idx, 2'b00} +: 4]]};
      end
    end
  end

endmodule
